// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives a request/ack instruction memory port and
// presents one fetched instruction at a time to the IF/ID register, with
// branch redirect, downstream stall and discard of in-flight responses.
module if_fetch_unit #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hazard_detected,
   input  logic             pc_src,
   input  logic [PC_W-1:0]  branch_target,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [INS_W-1:0] imem_rdata,
   output logic [PC_W-1:0]  PC,
   output logic [PC_W-1:0]  PCPlus4,
   output logic [INS_W-1:0] inst_code,
   output logic             inst_valid
);

   localparam logic [INS_W-1:0] NOP  = INS_W'(32'h00000013);
   localparam logic [PC_W-1:0]  FOUR = PC_W'(4);

   typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

   state_e          state_q;
   logic [PC_W-1:0] pc_q;

   // Fetch FSM; every output is registered and updated alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         pc_q       <= '0;
         imem_req   <= 1'b0;
         imem_addr  <= '0;
         PC         <= '0;
         PCPlus4    <= FOUR;
         inst_code  <= NOP;
         inst_valid <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               // Any ack seen here is stale (abandoned by reset) and ignored.
               state_q  <= StReq;
               imem_req <= 1'b1;
               if (pc_src) begin
                  pc_q       <= branch_target;
                  imem_addr  <= branch_target;
                  inst_valid <= 1'b0;
                  inst_code  <= NOP;
               end else begin
                  imem_addr <= pc_q;
               end
            end
            StReq: begin
               if (pc_src) begin
                  pc_q       <= branch_target;
                  inst_valid <= 1'b0;
                  inst_code  <= NOP;
                  if (imem_ack) begin
                     // Response discarded; request the target straight away.
                     state_q   <= StReq;
                     imem_addr <= branch_target;
                  end else begin
                     // Old request must still complete before re-issuing.
                     state_q <= StDrop;
                  end
               end else if (imem_ack) begin
                  inst_code  <= imem_rdata;
                  PC         <= pc_q;
                  PCPlus4    <= pc_q + FOUR;
                  inst_valid <= 1'b1;
                  pc_q       <= pc_q + FOUR;
                  imem_req   <= 1'b0;
                  state_q    <= StHold;
               end
            end
            StHold: begin
               if (pc_src) begin
                  pc_q       <= branch_target;
                  inst_valid <= 1'b0;
                  inst_code  <= NOP;
                  imem_req   <= 1'b1;
                  imem_addr  <= branch_target;
                  state_q    <= StReq;
               end else if (!hazard_detected) begin
                  // Instruction consumed by IF/ID; fetch the next one.
                  inst_valid <= 1'b0;
                  inst_code  <= NOP;
                  imem_req   <= 1'b1;
                  imem_addr  <= pc_q;
                  state_q    <= StReq;
               end
            end
            StDrop: begin
               if (pc_src) begin
                  pc_q <= branch_target;
               end
               if (imem_ack) begin
                  state_q   <= StReq;
                  imem_addr <= pc_src ? branch_target : pc_q;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
